// File: rtl/alu_pipe_checker.sv
// Pipelined W-bit ALU with a built-in golden-result checker: per-result mismatch
// pulse, sticky error, saturating transaction/mismatch counters and first-failure capture.
module alu_pipe_checker #(
  parameter int W      = 32,
  parameter int STAGES = 2,   // legal range 1..4
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             c_in,
  input  logic [2:0]       alop,
  input  logic [W:0]       ref_result,
  input  logic             clr_err,
  output logic             out_valid,
  output logic [W:0]       result,
  output logic             zero,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] txn_cnt,
  output logic [CNT_W-1:0] fail_idx,
  output logic [2:0]       fail_alop
);

  localparam int SH_W = (W > 1) ? $clog2(W) : 1;

  logic [W:0] alu_next;
  logic       last_valid;
  logic [W:0] last_res;
  logic [W:0] last_ref;
  logic [2:0] last_alop;

  always_comb begin
    alu_next = '0;
    case (alop)
      3'b000:  alu_next = {1'b0, a & b};
      3'b001:  alu_next = {1'b0, a | b};
      3'b010:  alu_next = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
      3'b011:  alu_next = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, c_in};
      3'b100:  alu_next = {1'b0, a ^ b};
      3'b101:  alu_next = {{W{1'b0}}, ($signed(a) < $signed(b))};
      3'b110:  alu_next = {1'b0, a << b[SH_W-1:0]};
      default: alu_next = {1'b0, ~(a | b)};
    endcase
  end

  // Stage 0 holds the freshly computed result; later stages only delay it.
  // Only the valid bits are reset, data may go stale behind them.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic       valid_reg;
      logic [W:0] res_reg;
      logic [W:0] ref_reg;
      logic [2:0] alop_reg;

      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) valid_reg <= 1'b0;
          else     valid_reg <= in_valid;
          res_reg  <= alu_next;
          ref_reg  <= ref_result;
          alop_reg <= alop;
        end
      end else begin : g_delay
        always_ff @(posedge clk) begin
          if (rst) valid_reg <= 1'b0;
          else     valid_reg <= g_stage[gi-1].valid_reg;
          res_reg  <= g_stage[gi-1].res_reg;
          ref_reg  <= g_stage[gi-1].ref_reg;
          alop_reg <= g_stage[gi-1].alop_reg;
        end
      end
    end
  endgenerate

  assign last_valid = g_stage[STAGES-1].valid_reg;
  assign last_res   = g_stage[STAGES-1].res_reg;
  assign last_ref   = g_stage[STAGES-1].ref_reg;
  assign last_alop  = g_stage[STAGES-1].alop_reg;

  assign out_valid = last_valid;
  assign result    = last_valid ? last_res : '0;
  assign zero      = last_valid & (last_res[W-1:0] == '0);
  assign mismatch  = last_valid & (last_res != last_ref);

  // A clear coinciding with an output still records that output, so nothing is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky   <= 1'b0;
      mismatch_cnt <= '0;
      txn_cnt      <= '0;
      fail_idx     <= '0;
      fail_alop    <= '0;
    end else if (clr_err) begin
      err_sticky   <= mismatch;
      mismatch_cnt <= {{(CNT_W-1){1'b0}}, mismatch};
      txn_cnt      <= {{(CNT_W-1){1'b0}}, out_valid};
      fail_idx     <= '0;
      fail_alop    <= mismatch ? last_alop : 3'b000;
    end else begin
      if (out_valid && (txn_cnt != {CNT_W{1'b1}}))
        txn_cnt <= txn_cnt + CNT_W'(1);
      if (mismatch && (mismatch_cnt != {CNT_W{1'b1}}))
        mismatch_cnt <= mismatch_cnt + CNT_W'(1);
      if (mismatch && !err_sticky) begin
        fail_idx  <= txn_cnt;
        fail_alop <= last_alop;
      end
      if (mismatch)
        err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_pipe_checker.sv
// Scoreboard bench: two checker instances (16-bit and 2-bit counters) share one
// randomised/directed stimulus stream and are compared against a behavioural model.
module tb_alu_pipe_checker;
  localparam int STAGES = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       c_in = 1'b0;
  logic [2:0] alop = '0;
  logic [8:0] ref_result = '0;
  logic       clr_err = 1'b0;

  logic        ov0, z0, mm0, err0, ov1, z1, mm1, err1;
  logic [8:0]  res0, res1;
  logic [15:0] mcnt0, txn0, fidx0;
  logic [1:0]  mcnt1, txn1, fidx1;
  logic [2:0]  falop0, falop1;

  alu_pipe_checker #(.W(8), .STAGES(STAGES), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c_in(c_in), .alop(alop),
    .ref_result(ref_result), .clr_err(clr_err), .out_valid(ov0), .result(res0), .zero(z0),
    .mismatch(mm0), .err_sticky(err0), .mismatch_cnt(mcnt0), .txn_cnt(txn0),
    .fail_idx(fidx0), .fail_alop(falop0));

  alu_pipe_checker #(.W(8), .STAGES(STAGES), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c_in(c_in), .alop(alop),
    .ref_result(ref_result), .clr_err(clr_err), .out_valid(ov1), .result(res1), .zero(z1),
    .mismatch(mm1), .err_sticky(err1), .mismatch_cnt(mcnt1), .txn_cnt(txn1),
    .fail_idx(fidx1), .fail_alop(falop1));

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] res;
    logic [8:0] rf;
    logic [2:0] op;
    int         due;
  } item_t;

  item_t q[$];
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;

  int m_txn[2], m_mcnt[2], m_fidx[2], m_falop[2];
  bit m_err[2];
  int cap[2] = '{65535, 3};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [8:0] alu_model(logic [2:0] op, logic [7:0] x, logic [7:0] y, logic ci);
    int s, sx, sy;
    s = 0;
    case (op)
      3'd0: s = int'(x) & int'(y);
      3'd1: s = int'(x) | int'(y);
      3'd2: s = int'(x) + int'(y) + int'(ci);
      3'd3: s = (int'(x) - int'(y) - int'(ci)) & 'h1FF;
      3'd4: s = int'(x) ^ int'(y);
      3'd5: begin
        sx = (x >= 128) ? int'(x) - 256 : int'(x);
        sy = (y >= 128) ? int'(y) - 256 : int'(y);
        s  = (sx < sy) ? 1 : 0;
      end
      3'd6: s = (int'(x) << (int'(y) % 8)) & 'hFF;
      default: s = (~(int'(x) | int'(y))) & 'hFF;
    endcase
    return 9'(s);
  endfunction

  task automatic step(input bit v, input logic [2:0] op, input logic [7:0] aa, input logic [7:0] bb,
                      input bit ci, input bit corrupt, input bit clr, input bit rs);
    item_t      it;
    logic [8:0] e;
    @(posedge clk); #1;
    in_valid = v; alop = op; a = aa; b = bb; c_in = ci; clr_err = clr; rst = rs;
    e = alu_model(op, aa, bb, ci);
    ref_result = corrupt ? (e ^ (9'h1 << $urandom_range(0, 8))) : e;
    if (v && !rs) begin
      it.res = e; it.rf = ref_result; it.op = op; it.due = cyc + STAGES;
      q.push_back(it);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 3'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rnd_txn(input bit corrupt);
    step(1'b1, 3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), corrupt, 1'b0, 1'b0);
  endtask

  // Monitor: checks status against the model, then pops and checks any output.
  initial begin : monitor
    item_t it;
    bit    exp_ov, mm;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        chk("txn_cnt16", txn0, m_txn[0]);   chk("txn_cnt2", txn1, m_txn[1]);
        chk("mm_cnt16", mcnt0, m_mcnt[0]);  chk("mm_cnt2", mcnt1, m_mcnt[1]);
        chk("err16", err0, m_err[0]);       chk("err2", err1, m_err[1]);
        chk("fail_idx16", fidx0, m_fidx[0]); chk("fail_idx2", fidx1, m_fidx[1]);
        chk("fail_alop16", falop0, m_falop[0]); chk("fail_alop2", falop1, m_falop[1]);
        while (q.size() > 0 && q[0].due < cyc) begin
          total++; bad++;
          $display("FAIL missing_output: due %0d, now %0d", q[0].due, cyc);
          void'(q.pop_front());
        end
        exp_ov = (q.size() > 0) && (q[0].due == cyc);
        mm = 1'b0;
        chk("out_valid16", ov0, exp_ov);
        chk("out_valid2", ov1, exp_ov);
        if (exp_ov) begin
          it = q.pop_front();
          mm = (it.res != it.rf);
          $display("txn cyc=%0d op=%0d res=%03h ref=%03h mm=%0d", cyc, it.op, res0, it.rf, mm);
          chk("result16", res0, it.res);         chk("result2", res1, it.res);
          chk("zero16", z0, it.res[7:0] == 0);   chk("zero2", z1, it.res[7:0] == 0);
          chk("mismatch16", mm0, mm);            chk("mismatch2", mm1, mm);
        end else begin
          chk("idle_result", res0, 0);
          chk("idle_zero", z0, 0);
          chk("idle_mismatch", mm0 | mm1, 0);
        end
        for (int k = 0; k < 2; k++) begin
          if (rst) begin
            m_txn[k] = 0; m_mcnt[k] = 0; m_fidx[k] = 0; m_falop[k] = 0; m_err[k] = 0;
          end else if (clr_err) begin
            m_err[k] = mm; m_mcnt[k] = int'(mm); m_txn[k] = int'(exp_ov);
            m_fidx[k] = 0; m_falop[k] = mm ? int'(it.op) : 0;
          end else begin
            if (mm && !m_err[k]) begin m_fidx[k] = m_txn[k]; m_falop[k] = int'(it.op); end
            if (exp_ov && m_txn[k] < cap[k]) m_txn[k]++;
            if (mm && m_mcnt[k] < cap[k]) m_mcnt[k]++;
            if (mm) m_err[k] = 1'b1;
          end
        end
        if (rst) q.delete();
      end
    end
  end

  initial begin : watchdog
    #100000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin : driver
    for (int i = 0; i < 3; i++)
      step(1'b1, 3'd2, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    chk("reset_txn", txn0, 0);
    chk("reset_out_valid", ov0, 0);

    // ADD carry-out with zero low byte
    step(1'b1, 3'd2, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("add_txn", txn0, 1);

    // SUB borrow then signed SLT back-to-back
    step(1'b1, 3'd3, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd5, 8'h80, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("sub_slt_err", err0, 0);

    // Five transactions, third (XOR) corrupted
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    rnd_txn(1'b0); rnd_txn(1'b0);
    step(1'b1, 3'd4, 8'h5A, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0);
    rnd_txn(1'b0); rnd_txn(1'b0);
    idle(4);
    chk("five_fail_idx", fidx0, 2);
    chk("five_fail_alop", falop0, 4);
    chk("five_mm_cnt", mcnt0, 1);
    chk("five_txn", txn0, 5);

    // Second and fourth corrupted, then clear with work in flight
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    rnd_txn(1'b0); rnd_txn(1'b1); rnd_txn(1'b0); rnd_txn(1'b1); rnd_txn(1'b0);
    idle(4);
    chk("two_mm_cnt", mcnt0, 2);
    chk("two_fail_idx", fidx0, 1);
    rnd_txn(1'b0);
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4);

    // Reset with transactions in flight
    rnd_txn(1'b0);
    step(1'b1, 3'd1, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    chk("rst_drop_txn", txn0, 0);
    rnd_txn(1'b0);
    idle(4);
    chk("post_rst_txn", txn0, 1);

    // Saturation of 2-bit counters, then clear coinciding with a mismatch
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) rnd_txn(1'b1);
    idle(4);
    chk("sat_mm_cnt", mcnt1, 3);
    chk("sat_txn", txn1, 3);
    step(1'b1, 3'd6, 8'h81, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    chk("clr_mm_cnt", mcnt1, 1);
    chk("clr_err", err1, 1);
    chk("clr_fail_alop", falop0, 6);
    step(1'b1, 3'd7, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    chk("clr_clean_txn", txn0, 1);
    chk("clr_clean_mm", mcnt0, 0);

    // Random traffic with occasional corruption, clears and resets
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 79) == 0);
    idle(8);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
